ps2_key_fifo: RTL and testbench
===============================

Name: ps2_key_fifo

Overview:
- Keyboard event buffer between the HPS keyboard output and the CPU I/O space inside `system`. It sits directly upstream of the CPU's keyboard port.
- Converts the toggle-strobed 11-bit `ps2_key` word into discrete events and queues them in a show-ahead FIFO.
- Optionally suppresses typematic repeats so that software sees clean make/break events.
- Exposes a pop strobe, empty/count status and a sticky overflow flag for the CPU.

Parameters:
- DEPTH_LOG2, 4, log2 of FIFO depth (default 16 entries).
- FILTER_REPEAT, 1, when 1, drop a repeated make code that arrives without an intervening break.

Ports:
- clk_24  input  1  system clock; all logic sits on this single clock.
- reset  input  1  asynchronous, active-high reset.
- ps2_key  input  11  [10] event toggle, [9] pressed (1 = make), [8] extended (E0), [7:0] scancode.
- rd  input  1  pop strobe; one pop per asserted cycle.
- clr_overflow  input  1  clears the overflow flag.
- dout  output  10  head entry {pressed, extended, scancode}.
- empty  output  1  FIFO contains no entries.
- count  output  DEPTH_LOG2+1  number of entries held (0..2^DEPTH_LOG2).
- overflow  output  1  sticky flag: an event was lost because the FIFO was full.

Behaviour:
- Reset values: dout=0, empty=1, count=0, overflow=0; read pointer, write pointer and last_make cleared; state=S_PRIME.
- State S_PRIME:
  - Lasts exactly one cycle after reset deasserts.
  - Latches ps2_key[10] into tog_q; no push.
  - Moves to S_RUN. This prevents a spurious event when the toggle is already 1 at reset.
- State S_RUN:
  - event = ps2_key[10] != tog_q; tog_q <= ps2_key[10] every cycle.
  - Entry = {ps2_key[9], ps2_key[8], ps2_key[7:0]}.
- Repeat filter (FILTER_REPEAT=1):
  - A make event whose {ext, code} equals last_make, with last_make_valid=1, is discarded and leaves count unchanged.
  - An accepted make sets last_make and last_make_valid=1.
  - A break whose {ext, code} equals last_make clears last_make_valid.
  - A break for any other code is pushed and does not alter last_make.
- Push (push_req = accepted event):
  - When count < DEPTH: write at wptr; wptr++ wraps modulo DEPTH.
  - When count = DEPTH and rd=0: drop the event and set overflow=1. FIFO contents are unchanged.
  - When count = DEPTH and rd=1 in the same cycle: the pop frees a slot and the push succeeds. count stays DEPTH; overflow unaffected.
- Pop:
  - rd=1 with empty=0: rptr++ wraps modulo DEPTH.
  - rd=1 with empty=1: ignored; no pointer or count change and no underflow.
- Simultaneous push and pop with 0 < count < DEPTH: both occur and count is unchanged.
- Push into an empty FIFO with rd=1 in the same cycle: the pop is ignored and the entry is retained (count becomes 1).
- Show-ahead output:
  - dout equals mem[rptr] whenever empty=0.
  - A write into an empty FIFO appears on dout, with empty=0, on the cycle after the push edge (1-cycle latency).
  - After a pop, the next head is visible on the following cycle.
  - While empty=1, dout holds its last value.
- count and empty are registered and updated on the same edge as the pointers.
- overflow:
  - Set has priority over clr_overflow when both occur in the same cycle.
  - Otherwise clr_overflow=1 clears it on the next edge.
- Reset asserted mid-operation: all outputs, pointers and state return to reset values immediately (asynchronous). Queued events are discarded; memory contents need not be cleared.
- Back-to-back toggles on consecutive cycles each produce one event.
- The block has no clock enable and does not pause with the CPU; events keep queuing during pause.

Test Plan:
- Reset with ps2_key[10]=1 held, no further change for 10 cycles -> empty=1, count=0 throughout (no spurious push).
- Toggle with pressed=1, ext=0, code 8'h1C, then toggle with pressed=0, code 8'h1C -> count=2; dout=10'h21C; pulse rd -> dout=10'h01C; pulse rd -> empty=1, count=0.
- FILTER_REPEAT=1: three make events for 8'h1C, then break 8'h1C, then make 8'h1C -> queue holds exactly 10'h21C, 10'h01C, 10'h21C (count=3).
- 17 distinct make events with no rd (DEPTH_LOG2=4) -> count=16, overflow=1, head still the first event. Pulse clr_overflow -> overflow=0.
- With count=16, issue a toggle and rd in the same cycle -> count stays 16, overflow stays 0, newest entry lands at the tail. With count=5, push+rd -> count stays 5.
- Assert reset with count=7 -> empty=1, count=0, overflow=0 within the same cycle. After release, the first toggle is primed-out only if it coincides with the S_PRIME cycle; otherwise it is queued.

Source files
------------

// File: rtl/ps2_key_fifo_if.sv
// Bus between the keyboard event buffer and its CPU-side user.
// Master drives the keyboard word and read/clear strobes; slave is the FIFO.
interface ps2_key_fifo_if #(
    parameter int DEPTH_LOG2 = 4
);
    logic [10:0]         ps2_key;
    logic                rd;
    logic                clr_overflow;
    logic [9:0]          dout;
    logic                empty;
    logic [DEPTH_LOG2:0] count;
    logic                overflow;

    modport master (
        output ps2_key, rd, clr_overflow,
        input  dout, empty, count, overflow
    );

    modport slave (
        input  ps2_key, rd, clr_overflow,
        output dout, empty, count, overflow
    );
endinterface

// File: rtl/ps2_key_fifo.sv
// Keyboard event buffer: turns the toggle-strobed ps2_key word into events,
// optionally drops typematic repeats, and queues them in a show-ahead FIFO.
module ps2_key_fifo #(
    parameter int DEPTH_LOG2    = 4,
    parameter bit FILTER_REPEAT = 1'b1
) (
    input  logic           clk_24,
    input  logic           reset,
    ps2_key_fifo_if.slave  bus
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int CW    = DEPTH_LOG2 + 1;

    typedef enum logic {S_PRIME, S_RUN} state_e;

    state_e                state_q, state_d;
    logic                  tog_q, tog_d;
    logic [DEPTH_LOG2-1:0] rptr_q, rptr_d;
    logic [DEPTH_LOG2-1:0] wptr_q, wptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  empty_q, empty_d;
    logic                  ovf_q, ovf_d;
    logic [9:0]            dout_q, dout_d;
    logic [8:0]            lm_q, lm_d;
    logic                  lmv_q, lmv_d;

    logic [9:0]            mem [DEPTH];

    logic                  ev;
    logic                  rep_hit;
    logic                  push_req;
    logic                  push_ok;
    logic                  pop_ok;
    logic                  full;
    logic [9:0]            entry;

    assign entry = bus.ps2_key[9:0];

    // NOTE: every signal assigned here gets a default first, so no path leaves it unassigned (no latches).
    always_comb begin
        state_d = state_q;
        tog_d   = bus.ps2_key[10];
        ev      = 1'b0;
        case (state_q)
            S_PRIME: state_d = S_RUN;
            S_RUN:   ev      = (bus.ps2_key[10] != tog_q);
            default: state_d = S_PRIME;
        endcase

        // A make matching the last accepted make with no break in between is a typematic repeat.
        rep_hit  = FILTER_REPEAT && bus.ps2_key[9] && lmv_q && (lm_q == bus.ps2_key[8:0]);
        push_req = ev && !rep_hit;

        lm_d  = lm_q;
        lmv_d = lmv_q;
        if (FILTER_REPEAT && push_req) begin
            if (bus.ps2_key[9]) begin
                lm_d  = bus.ps2_key[8:0];
                lmv_d = 1'b1;
            end else if (lm_q == bus.ps2_key[8:0]) begin
                lmv_d = 1'b0;
            end
        end

        full    = (count_q == CW'(DEPTH));
        pop_ok  = bus.rd && !empty_q;
        push_ok = push_req && (!full || bus.rd);

        rptr_d  = pop_ok  ? rptr_q + 1'b1 : rptr_q;
        wptr_d  = push_ok ? wptr_q + 1'b1 : wptr_q;
        count_d = count_q;
        if (push_ok && !pop_ok)
            count_d = count_q + CW'(1);
        else if (pop_ok && !push_ok)
            count_d = count_q - CW'(1);
        empty_d = (count_d == '0);

        ovf_d = ovf_q;
        if (push_req && full && !bus.rd)
            ovf_d = 1'b1;
        else if (bus.clr_overflow)
            ovf_d = 1'b0;

        // The new head may be the entry written this very edge, so bypass the memory then.
        dout_d = dout_q;
        if (!empty_d)
            dout_d = (push_ok && (rptr_d == wptr_q)) ? entry : mem[rptr_d];
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk_24 or posedge reset) begin
        if (reset) begin
            state_q <= S_PRIME;
            tog_q   <= 1'b0;
            rptr_q  <= '0;
            wptr_q  <= '0;
            count_q <= '0;
            empty_q <= 1'b1;
            ovf_q   <= 1'b0;
            dout_q  <= '0;
            lm_q    <= '0;
            lmv_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            tog_q   <= tog_d;
            rptr_q  <= rptr_d;
            wptr_q  <= wptr_d;
            count_q <= count_d;
            empty_q <= empty_d;
            ovf_q   <= ovf_d;
            dout_q  <= dout_d;
            lm_q    <= lm_d;
            lmv_q   <= lmv_d;
        end
    end

    // NOTE: storage is deliberately not reset; pointers and count define which entries are valid.
    always_ff @(posedge clk_24) begin
        if (push_ok)
            mem[wptr_q] <= entry;
    end

    assign bus.dout     = dout_q;
    assign bus.empty    = empty_q;
    assign bus.count    = count_q;
    assign bus.overflow = ovf_q;
endmodule

// File: tb/tb_ps2_key_fifo.sv
// Self-checking bench for ps2_key_fifo: directed scenarios plus random traffic,
// compared every cycle against a queue-based model of the event buffer.
module tb_ps2_key_fifo;
    localparam int DL    = 4;
    localparam int DEPTH = 1 << DL;

    logic clk_24 = 1'b0;
    logic reset  = 1'b1;

    ps2_key_fifo_if #(.DEPTH_LOG2(DL)) bus ();

    ps2_key_fifo #(.DEPTH_LOG2(DL), .FILTER_REPEAT(1'b1)) dut (
        .clk_24 (clk_24),
        .reset  (reset),
        .bus    (bus)
    );

    always #5 clk_24 = ~clk_24;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state
    logic [9:0] q[$];
    bit         m_ovf;
    logic [8:0] m_lm;
    bit         m_lmv;
    bit         m_tog;
    bit         m_prime;
    logic [9:0] m_dout;

    logic       tog_r;
    logic [9:0] key_lo;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_ovf   = 1'b0;
        m_lm    = '0;
        m_lmv   = 1'b0;
        m_tog   = 1'b0;
        m_prime = 1'b1;
        m_dout  = '0;
    endtask

    task automatic model_edge(input logic [10:0] key, input logic rd, input logic clr);
        bit is_ev, push, ovf_set;
        int pre;
        is_ev = 1'b0;
        push  = 1'b0;
        ovf_set = 1'b0;
        if (m_prime) m_prime = 1'b0;
        else         is_ev = (key[10] != m_tog);
        m_tog = key[10];
        if (is_ev) begin
            if (key[9] && m_lmv && (m_lm == key[8:0])) begin
                push = 1'b0;
            end else begin
                push = 1'b1;
                if (key[9]) begin
                    m_lm  = key[8:0];
                    m_lmv = 1'b1;
                end else if (m_lm == key[8:0]) begin
                    m_lmv = 1'b0;
                end
            end
        end
        pre = q.size();
        if (rd && pre > 0) void'(q.pop_front());
        if (push) begin
            if (pre < DEPTH || rd) q.push_back(key[9:0]);
            else ovf_set = 1'b1;
        end
        if (ovf_set)  m_ovf = 1'b1;
        else if (clr) m_ovf = 1'b0;
        if (q.size() > 0) m_dout = q[0];
    endtask

    task automatic check_all();
        check("count",    16'(bus.count),    16'(q.size()));
        check("empty",    16'(bus.empty),    16'(q.size() == 0));
        check("overflow", 16'(bus.overflow), 16'(m_ovf));
        check("dout",     16'(bus.dout),     16'(m_dout));
    endtask

    task automatic step(input logic rd, input logic clr);
        logic [10:0] k;
        k = {tog_r, key_lo};
        bus.ps2_key      = k;
        bus.rd           = rd;
        bus.clr_overflow = clr;
        @(posedge clk_24);
        model_edge(k, rd, clr);
        #1;
        bus.rd           = 1'b0;
        bus.clr_overflow = 1'b0;
        check_all();
    endtask

    task automatic ev(input logic pressed, input logic ext, input logic [7:0] code,
                      input logic rd, input logic clr);
        tog_r  = ~tog_r;
        key_lo = {pressed, ext, code};
        step(rd, clr);
    endtask

    task automatic idle(input logic rd, input logic clr);
        step(rd, clr);
    endtask

    initial begin
        model_reset();
        tog_r            = 1'b1;
        key_lo           = '0;
        bus.ps2_key      = 11'h400;
        bus.rd           = 1'b0;
        bus.clr_overflow = 1'b0;

        // Reset held with the toggle already high.
        repeat (3) @(posedge clk_24);
        #1;
        check("rst_empty", 16'(bus.empty),    16'd1);
        check("rst_count", 16'(bus.count),    16'd0);
        check("rst_ovf",   16'(bus.overflow), 16'd0);
        check("rst_dout",  16'(bus.dout),     16'd0);
        reset = 1'b0;
        for (int i = 0; i < 10; i++) idle(1'b0, 1'b0);
        check("no_spurious", 16'(bus.count), 16'd0);

        // Make then break of 1C, then pop both.
        ev(1'b1, 1'b0, 8'h1C, 1'b0, 1'b0);
        ev(1'b0, 1'b0, 8'h1C, 1'b0, 1'b0);
        check("mb_count", 16'(bus.count), 16'd2);
        check("mb_head",  16'(bus.dout),  16'h21C);
        idle(1'b1, 1'b0);
        check("mb_head2", 16'(bus.dout),  16'h01C);
        idle(1'b1, 1'b0);
        check("mb_empty", 16'(bus.empty), 16'd1);

        // Typematic repeats filtered.
        ev(1'b1, 1'b0, 8'h1C, 1'b0, 1'b0);
        ev(1'b1, 1'b0, 8'h1C, 1'b0, 1'b0);
        ev(1'b1, 1'b0, 8'h1C, 1'b0, 1'b0);
        ev(1'b0, 1'b0, 8'h1C, 1'b0, 1'b0);
        ev(1'b1, 1'b0, 8'h1C, 1'b0, 1'b0);
        check("rep_count", 16'(bus.count), 16'd3);
        check("rep_e0", 16'(bus.dout), 16'h21C);
        idle(1'b1, 1'b0);
        check("rep_e1", 16'(bus.dout), 16'h01C);
        idle(1'b1, 1'b0);
        check("rep_e2", 16'(bus.dout), 16'h21C);
        idle(1'b1, 1'b0);

        // Overflow: 17 distinct makes into a 16-deep queue.
        for (int i = 0; i < DEPTH + 1; i++) ev(1'b1, 1'b0, 8'(8'h20 + i), 1'b0, 1'b0);
        check("ovf_count", 16'(bus.count),    16'd16);
        check("ovf_flag",  16'(bus.overflow), 16'd1);
        check("ovf_head",  16'(bus.dout),     16'h220);
        idle(1'b0, 1'b1);
        check("ovf_clr",   16'(bus.overflow), 16'd0);

        // Push+pop while full, then push+pop at count 5.
        ev(1'b1, 1'b1, 8'h70, 1'b1, 1'b0);
        check("fullpp_count", 16'(bus.count),    16'd16);
        check("fullpp_ovf",   16'(bus.overflow), 16'd0);
        check("fullpp_head",  16'(bus.dout),     16'h221);
        for (int i = 0; i < 11; i++) idle(1'b1, 1'b0);
        check("five_count", 16'(bus.count), 16'd5);
        ev(1'b0, 1'b1, 8'h71, 1'b1, 1'b0);
        check("fivepp_count", 16'(bus.count), 16'd5);
        for (int i = 0; i < 6; i++) idle(1'b1, 1'b0);
        check("drain_empty", 16'(bus.empty), 16'd1);

        // Push into empty with a simultaneous read: entry retained.
        ev(1'b0, 1'b0, 8'h33, 1'b1, 1'b0);
        check("emptypp_count", 16'(bus.count), 16'd1);
        check("emptypp_head",  16'(bus.dout),  16'h033);
        idle(1'b1, 1'b0);

        // Random traffic: fill-heavy phase then drain-heavy phase.
        for (int ph = 0; ph < 2; ph++) begin
            for (int i = 0; i < 300; i++) begin
                logic [7:0] c;
                logic       r;
                case ($urandom_range(2))
                    0:       c = 8'h1C;
                    1:       c = 8'h1D;
                    default: c = 8'h5A;
                endcase
                r = ($urandom_range(99) < ((ph == 0) ? 15 : 70));
                if ($urandom_range(99) < 60)
                    ev(1'($urandom), 1'($urandom), c, r, ($urandom_range(99) < 5));
                else
                    idle(r, ($urandom_range(99) < 5));
            end
        end

        // Drain, then build count 7 with break codes and reset mid-operation.
        for (int i = 0; i < 2 * DEPTH && q.size() > 0; i++) idle(1'b1, 1'b0);
        for (int i = 0; i < 7; i++) ev(1'b0, 1'b0, 8'(8'h40 + i), 1'b0, 1'b0);
        check("pre_rst_count", 16'(bus.count), 16'd7);
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        check("arst_empty", 16'(bus.empty),    16'd1);
        check("arst_count", 16'(bus.count),    16'd0);
        check("arst_ovf",   16'(bus.overflow), 16'd0);
        @(posedge clk_24);
        #1;
        reset = 1'b0;
        // Toggle coincides with the prime cycle: absorbed.
        ev(1'b1, 1'b0, 8'h29, 1'b0, 1'b0);
        check("prime_absorb", 16'(bus.count), 16'd0);
        ev(1'b1, 1'b0, 8'h29, 1'b0, 1'b0);
        check("post_prime_count", 16'(bus.count), 16'd1);
        check("post_prime_head",  16'(bus.dout),  16'h229);
        // Back-to-back toggles each count.
        ev(1'b0, 1'b0, 8'h29, 1'b0, 1'b0);
        ev(1'b1, 1'b1, 8'h11, 1'b0, 1'b0);
        check("b2b_count", 16'(bus.count), 16'd3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
